// File: rtl/approx_mult_err_monitor_if.sv
// Sample/result handshake bundle for the approximate-multiplier error monitor.
// The master side feeds samples and takes results; the slave side is the monitor.
interface approx_mult_err_monitor_if #(
    parameter int WIDTH    = 8,
    parameter int WIN_LOG2 = 8
);
    localparam int ACC_W = 2*WIDTH + WIN_LOG2;

    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_x;
    logic [WIDTH-1:0]     in_y;
    logic [2*WIDTH-1:0]   in_z;
    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_W-1:0]     res_sum_abs;
    logic [ACC_W:0]       res_sum_err;
    logic [2*WIDTH-1:0]   res_max_abs;
    logic [WIDTH-1:0]     res_max_x;
    logic [WIDTH-1:0]     res_max_y;
    logic [WIN_LOG2:0]    res_err_cnt;
    logic                 busy;

    modport master (
        output start, in_valid, in_x, in_y, in_z, res_ready,
        input  in_ready, res_valid, res_sum_abs, res_sum_err, res_max_abs,
               res_max_x, res_max_y, res_err_cnt, busy
    );

    modport slave (
        input  start, in_valid, in_x, in_y, in_z, res_ready,
        output in_ready, res_valid, res_sum_abs, res_sum_err, res_max_abs,
               res_max_x, res_max_y, res_err_cnt, busy
    );
endinterface

// File: rtl/approx_mult_err_monitor.sv
// Scores an approximate multiplier: err = x*y - z, windowed |err|/err sums, max and count.
// Two-stage pipeline, results 3 cycles after the last accept; in_ready is registered, results held until res_ready.
module approx_mult_err_monitor #(
    parameter int WIDTH    = 8,
    parameter int WIN_LOG2 = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    approx_mult_err_monitor_if.slave  mon
);
    localparam int ACC_W = 2*WIDTH + WIN_LOG2;
    localparam logic [WIN_LOG2:0] WIN_LAST = {1'b0, {WIN_LOG2{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

    state_t               state;
    logic [WIN_LOG2:0]    cnt;
    logic [1:0]           dcnt;
    logic                 in_ready_q;
    logic                 res_valid_q;
    logic [ACC_W-1:0]     res_sum_abs_q;
    logic [ACC_W:0]       res_sum_err_q;
    logic [2*WIDTH-1:0]   res_max_abs_q;
    logic [WIDTH-1:0]     res_max_x_q;
    logic [WIDTH-1:0]     res_max_y_q;
    logic [WIN_LOG2:0]    res_err_cnt_q;

    logic                 s1_vld;
    logic [WIDTH-1:0]     s1_x;
    logic [WIDTH-1:0]     s1_y;
    logic [2*WIDTH:0]     s1_err;
    logic [ACC_W-1:0]     sum_abs;
    logic [ACC_W:0]       sum_err;
    logic [2*WIDTH-1:0]   max_abs;
    logic [WIDTH-1:0]     max_x;
    logic [WIDTH-1:0]     max_y;
    logic [WIN_LOG2:0]    err_cnt;

    logic                 accept;
    logic                 clr;
    logic [2*WIDTH-1:0]   prod;
    logic [2*WIDTH:0]     err_in;
    logic [2*WIDTH-1:0]   abs_err;

    assign accept = in_ready_q && mon.in_valid;
    assign clr    = (state == IDLE) && mon.start;

    always_comb begin
        prod    = {{WIDTH{1'b0}}, mon.in_x} * {{WIDTH{1'b0}}, mon.in_y};
        err_in  = {1'b0, prod} - {1'b0, mon.in_z};
        abs_err = s1_err[2*WIDTH] ? (~s1_err[2*WIDTH-1:0] + 1'b1) : s1_err[2*WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            dcnt          <= '0;
            in_ready_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_sum_abs_q <= '0;
            res_sum_err_q <= '0;
            res_max_abs_q <= '0;
            res_max_x_q   <= '0;
            res_max_y_q   <= '0;
            res_err_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mon.start) begin
                        state      <= ACCUM;
                        cnt        <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == WIN_LAST) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                            dcnt       <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // Hold until the final sample has cleared both pipeline stages.
                    if (dcnt == 2'd2) begin
                        state         <= REPORT;
                        res_valid_q   <= 1'b1;
                        res_sum_abs_q <= sum_abs;
                        res_sum_err_q <= sum_err;
                        res_max_abs_q <= max_abs;
                        res_max_x_q   <= max_x;
                        res_max_y_q   <= max_y;
                        res_err_cnt_q <= err_cnt;
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                REPORT: begin
                    if (mon.res_ready) begin
                        state       <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_err  <= '0;
            sum_abs <= '0;
            sum_err <= '0;
            max_abs <= '0;
            max_x   <= '0;
            max_y   <= '0;
            err_cnt <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_x   <= mon.in_x;
                s1_y   <= mon.in_y;
                s1_err <= err_in;
            end
            if (clr) begin
                sum_abs <= '0;
                sum_err <= '0;
                max_abs <= '0;
                max_x   <= '0;
                max_y   <= '0;
                err_cnt <= '0;
            end else if (s1_vld) begin
                sum_abs <= sum_abs + {{WIN_LOG2{1'b0}}, abs_err};
                sum_err <= sum_err + {{WIN_LOG2{s1_err[2*WIDTH]}}, s1_err};
                err_cnt <= err_cnt + {{WIN_LOG2{1'b0}}, |s1_err};
                // Strict compare keeps the earliest sample on ties.
                if (abs_err > max_abs) begin
                    max_abs <= abs_err;
                    max_x   <= s1_x;
                    max_y   <= s1_y;
                end
            end
        end
    end

    assign mon.in_ready    = in_ready_q;
    assign mon.res_valid   = res_valid_q;
    assign mon.res_sum_abs = res_sum_abs_q;
    assign mon.res_sum_err = res_sum_err_q;
    assign mon.res_max_abs = res_max_abs_q;
    assign mon.res_max_x   = res_max_x_q;
    assign mon.res_max_y   = res_max_y_q;
    assign mon.res_err_cnt = res_err_cnt_q;
    assign mon.busy        = (state != IDLE);
endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Randomised bench for the error monitor: small-window directed/random windows plus a full 256-sample window.
module tb_approx_mult_err_monitor;
    logic clk;
    logic rst_n;

    approx_mult_err_monitor_if #(.WIDTH(8), .WIN_LOG2(2)) m2 ();
    approx_mult_err_monitor_if #(.WIDTH(8), .WIN_LOG2(8)) m8 ();

    approx_mult_err_monitor #(.WIDTH(8), .WIN_LOG2(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (m2)
    );
    approx_mult_err_monitor #(.WIDTH(8), .WIN_LOG2(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (m8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;
    int qx[$];
    int qy[$];
    int qz[$];
    longint m_sabs;
    longint m_serr;
    int m_max;
    int m_mx;
    int m_my;
    int m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mask(input longint v, input int w);
        return 64'(v) & ((64'd1 << w) - 64'd1);
    endfunction

    // Window statistics straight from err = x*y - z over the queued samples.
    task automatic model_calc();
        longint e;
        m_sabs = 0; m_serr = 0; m_max = 0; m_mx = 0; m_my = 0; m_cnt = 0;
        foreach (qx[i]) begin
            e = longint'(qx[i]) * longint'(qy[i]) - longint'(qz[i]);
            m_serr += e;
            if (e < 0) e = -e;
            m_sabs += e;
            if (e != 0) m_cnt++;
            if (e > m_max) begin
                m_max = int'(e);
                m_mx  = qx[i];
                m_my  = qy[i];
            end
        end
    endtask

    task automatic check_res2(input string tag);
        model_calc();
        chk({tag, "_sum_abs"}, m2.res_sum_abs, mask(m_sabs, 18));
        chk({tag, "_sum_err"}, m2.res_sum_err, mask(m_serr, 19));
        chk({tag, "_max_abs"}, m2.res_max_abs, 64'(m_max));
        chk({tag, "_max_x"},   m2.res_max_x,   64'(m_mx));
        chk({tag, "_max_y"},   m2.res_max_y,   64'(m_my));
        chk({tag, "_err_cnt"}, m2.res_err_cnt, 64'(m_cnt));
    endtask

    task automatic start2();
        m2.start = 1'b1;
        step();
        m2.start = 1'b0;
        chk("start_in_ready", m2.in_ready, 1);
        chk("start_busy", m2.busy, 1);
    endtask

    task automatic send2(input int first, input int count, input int maxgap);
        bit rdy;
        int n;
        for (int i = first; i < first + count; i++) begin
            repeat ($urandom_range(maxgap, 0)) begin
                m2.in_x = 8'($urandom);
                step();
            end
            m2.in_valid = 1'b1;
            m2.in_x = 8'(qx[i]);
            m2.in_y = 8'(qy[i]);
            m2.in_z = 16'(qz[i]);
            n = 0;
            do begin
                rdy = m2.in_ready;
                step();
                n++;
            end while (!rdy && n < 50);
            if (!rdy) chk("accept_timeout", 0, 1);
            m2.in_valid = 1'b0;
        end
    endtask

    // Full window: last accept edge t is just behind us; results must appear after t+3.
    task automatic run2(input string tag, input int maxgap);
        start2();
        send2(0, 4, maxgap);
        chk({tag, "_drain_rdy"}, m2.in_ready, 0);
        chk({tag, "_rv_t1"}, m2.res_valid, 0);
        step();
        chk({tag, "_rv_t2"}, m2.res_valid, 0);
        step();
        chk({tag, "_rv_t3"}, m2.res_valid, 0);
        step();
        chk({tag, "_rv_t4"}, m2.res_valid, 1);
        check_res2(tag);
    endtask

    task automatic consume2(input string tag);
        m2.res_ready = 1'b1;
        step();
        m2.res_ready = 1'b0;
        chk({tag, "_rv_drop"}, m2.res_valid, 0);
        chk({tag, "_idle"}, m2.busy, 0);
    endtask

    task automatic load_sc1();
        qx = '{3, 3, 10, 255};
        qy = '{5, 5, 10, 255};
        qz = '{15, 16, 96, 65025};
    endtask

    task automatic check_sc1_consts(input string tag);
        chk({tag, "_c_sum_abs"}, m2.res_sum_abs, 5);
        chk({tag, "_c_sum_err"}, m2.res_sum_err, 3);
        chk({tag, "_c_max_abs"}, m2.res_max_abs, 4);
        chk({tag, "_c_max_x"},   m2.res_max_x, 10);
        chk({tag, "_c_max_y"},   m2.res_max_y, 10);
        chk({tag, "_c_err_cnt"}, m2.res_err_cnt, 2);
    endtask

    initial begin
        logic [63:0] h_sabs, h_serr, h_max, h_cnt;
        int x, y, p, r, acc, n;
        bit rdy;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        m2.start = 0; m2.in_valid = 0; m2.in_x = 0; m2.in_y = 0; m2.in_z = 0; m2.res_ready = 0;
        m8.start = 0; m8.in_valid = 0; m8.in_x = 0; m8.in_y = 0; m8.in_z = 0; m8.res_ready = 0;
        repeat (3) step();
        chk("rst_in_ready", m2.in_ready, 0);
        chk("rst_res_valid", m2.res_valid, 0);
        chk("rst_busy", m2.busy, 0);
        chk("rst_sum_abs", m2.res_sum_abs, 0);
        chk("rst_err_cnt", m2.res_err_cnt, 0);
        rst_n = 1'b1;
        step();

        // 1: basic window
        load_sc1();
        run2("s1", 0);
        check_sc1_consts("s1");
        consume2("s1");

        // 2: extremes of positive and negative error
        qx = '{255, 255, 255, 255}; qy = '{255, 255, 255, 255}; qz = '{0, 0, 0, 0};
        run2("s2a", 0);
        chk("s2a_c_sum_abs", m2.res_sum_abs, 260100);
        chk("s2a_c_max_abs", m2.res_max_abs, 65025);
        consume2("s2a");
        qx = '{0, 0, 0, 0}; qy = '{7, 7, 7, 7}; qz = '{65535, 65535, 65535, 65535};
        run2("s2b", 0);
        chk("s2b_c_sum_err", m2.res_sum_err, mask(-262140, 19));
        chk("s2b_c_max_abs", m2.res_max_abs, 65535);
        consume2("s2b");

        // 3: tie keeps the earliest sample
        qx = '{2, 4, 1, 0}; qy = '{9, 4, 1, 0}; qz = '{11, 9, 1, 0};
        run2("s3", 0);
        chk("s3_c_max_x", m2.res_max_x, 2);
        chk("s3_c_max_y", m2.res_max_y, 9);
        chk("s3_c_err_cnt", m2.res_err_cnt, 2);
        consume2("s3");

        // 4: random gaps, held results, start ignored outside IDLE
        for (int w = 0; w < 3; w++) begin
            qx.delete(); qy.delete(); qz.delete();
            for (int i = 0; i < 4; i++) begin
                qx.push_back($urandom_range(255, 0));
                qy.push_back($urandom_range(255, 0));
                qz.push_back($urandom_range(65535, 0));
            end
            run2("s4", 3);
            h_sabs = m2.res_sum_abs; h_serr = m2.res_sum_err;
            h_max = m2.res_max_abs; h_cnt = m2.res_err_cnt;
            for (int k = 0; k < 6; k++) begin
                m2.start = (k == 2);
                step();
                m2.start = 1'b0;
                chk("s4_hold_sum_abs", m2.res_sum_abs, h_sabs);
                chk("s4_hold_sum_err", m2.res_sum_err, h_serr);
                chk("s4_hold_max_abs", m2.res_max_abs, h_max);
                chk("s4_hold_err_cnt", m2.res_err_cnt, h_cnt);
                chk("s4_hold_rv", m2.res_valid, 1);
                chk("s4_hold_rdy", m2.in_ready, 0);
            end
            consume2("s4");
            step();
            chk("s4_start_ignored", m2.in_ready, 0);
        end

        // 5: reset mid-window, then a clean window
        load_sc1();
        start2();
        send2(0, 2, 1);
        rst_n = 1'b0;
        #1;
        chk("s5_rdy", m2.in_ready, 0);
        chk("s5_rv", m2.res_valid, 0);
        chk("s5_busy", m2.busy, 0);
        chk("s5_sum_abs", m2.res_sum_abs, 0);
        chk("s5_sum_err", m2.res_sum_err, 0);
        chk("s5_max_abs", m2.res_max_abs, 0);
        chk("s5_max_x", m2.res_max_x, 0);
        chk("s5_err_cnt", m2.res_err_cnt, 0);
        step();
        rst_n = 1'b1;
        step();
        run2("s5b", 0);
        check_sc1_consts("s5b");
        consume2("s5b");

        // 6: 256-sample window against a truncating/perturbed multiplier model
        qx.delete(); qy.delete(); qz.delete();
        m8.start = 1'b1;
        step();
        m8.start = 1'b0;
        acc = 0; n = 0;
        while (acc < 256 && n < 3000) begin
            x = $urandom_range(255, 0);
            y = $urandom_range(255, 0);
            p = x * y;
            r = $urandom_range(6, 0);
            case ($urandom_range(3, 0))
                0: p = p;
                1: p = p & ~((1 << r) - 1);
                2: p = ((p | ((1 << r) - 1)) > 65535) ? 65535 : (p | ((1 << r) - 1));
                default: p = $urandom_range(65535, 0);
            endcase
            m8.in_valid = ($urandom_range(3, 0) != 0);
            m8.in_x = 8'(x); m8.in_y = 8'(y); m8.in_z = 16'(p);
            rdy = m8.in_ready && m8.in_valid;
            step();
            n++;
            if (rdy) begin
                qx.push_back(x); qy.push_back(y); qz.push_back(p);
                acc++;
            end
        end
        m8.in_valid = 1'b0;
        if (acc < 256) chk("s6_accept_timeout", 64'(acc), 256);
        n = 0;
        while (!m8.res_valid && n < 20) begin
            step();
            n++;
        end
        chk("s6_res_valid", m8.res_valid, 1);
        model_calc();
        chk("s6_sum_abs", m8.res_sum_abs, mask(m_sabs, 24));
        chk("s6_sum_err", m8.res_sum_err, mask(m_serr, 25));
        chk("s6_max_abs", m8.res_max_abs, 64'(m_max));
        chk("s6_max_x", m8.res_max_x, 64'(m_mx));
        chk("s6_max_y", m8.res_max_y, 64'(m_my));
        chk("s6_err_cnt", m8.res_err_cnt, 64'(m_cnt));
        m8.res_ready = 1'b1;
        step();
        m8.res_ready = 1'b0;
        chk("s6_rv_drop", m8.res_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
